// File: rtl/plate_pkg.sv
// Shared types and constants for the licence-plate frame controller.
package plate_pkg;

  localparam logic [7:0]  HEAD_BYTE_DEFAULT = 8'hAA;
  localparam logic [7:0]  TAIL_BYTE_DEFAULT = 8'h55;
  localparam int unsigned PLATE_BYTES       = 7;
  localparam int unsigned PLATE_W           = 8 * PLATE_BYTES;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StCheck,
    StTail
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TAIL    = 2'd3
  } err_code_e;

endpackage

// File: rtl/plate_frame_ctrl_if.sv
// Byte-stream input and plate-word output bundle for plate_frame_ctrl.
// The master side is the UART receiver plus the plate consumer; the slave side is the controller.
interface plate_frame_ctrl_if;
  logic        rx_done;
  logic [7:0]  data_byte;
  logic        plate_ack;
  logic [55:0] plate_data;
  logic        plate_valid;
  logic        overrun;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic        busy;
  logic [7:0]  good_cnt;

  modport master (
    output rx_done, data_byte, plate_ack,
    input  plate_data, plate_valid, overrun, err_pulse, err_code, busy, good_cnt
  );

  modport slave (
    input  rx_done, data_byte, plate_ack,
    output plate_data, plate_valid, overrun, err_pulse, err_code, busy, good_cnt
  );
endinterface

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: counts idle cycles while a frame is open and flags the terminal cycle.
module byte_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] Terminal = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q;

  // Clear on every accepted byte or when no frame is open; hold at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!run || kick) begin
      cnt_q <= '0;
    end else if (cnt_q != Terminal) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A byte arriving on the terminal cycle wins over the timeout.
  assign expired = run && !kick && (cnt_q == Terminal);

endmodule

// File: rtl/plate_frame_ctrl.sv
// Frames the UART byte stream into checksummed 7-byte plate words with a valid/ack handshake.
module plate_frame_ctrl
  import plate_pkg::*;
#(
  parameter logic [7:0]  HEAD_BYTE   = HEAD_BYTE_DEFAULT,
  parameter logic [7:0]  TAIL_BYTE   = TAIL_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input logic               clk,
  input logic               rst_n,
  plate_frame_ctrl_if.slave bus
);

  state_e               state_q;
  logic [2:0]           idx_q;
  logic [7:0]           csum_q;
  logic [PLATE_W-1:0]   shadow_q;
  logic [PLATE_W-1:0]   plate_data_q;
  logic                 plate_valid_q;
  logic                 overrun_q;
  logic                 err_pulse_q;
  err_code_e            err_code_q;
  logic                 busy_q;
  logic [7:0]           good_cnt_q;
  logic                 expired;
  logic                 timer_run;

  assign timer_run = (state_q != StIdle);

  byte_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (timer_run),
    .kick    (bus.rx_done),
    .expired (expired)
  );

  // Frame FSM, checksum, shadow capture and consumer handshake with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      csum_q        <= '0;
      shadow_q      <= '0;
      plate_data_q  <= '0;
      plate_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      busy_q        <= 1'b0;
      good_cnt_q    <= '0;
    end else begin
      err_pulse_q <= 1'b0;

      // Ack only matters while data is pending; a completing frame below may re-set valid.
      if (bus.plate_ack && plate_valid_q) begin
        plate_valid_q <= 1'b0;
        overrun_q     <= 1'b0;
      end

      if (expired) begin
        state_q     <= StIdle;
        busy_q      <= 1'b0;
        err_pulse_q <= 1'b1;
        err_code_q  <= ERR_TIMEOUT;
      end else if (bus.rx_done) begin
        unique case (state_q)
          StIdle: begin
            if (bus.data_byte == HEAD_BYTE) begin
              state_q <= StPayload;
              busy_q  <= 1'b1;
              idx_q   <= '0;
              csum_q  <= '0;
            end
          end
          StPayload: begin
            // Header value is plain data here; no resync mid-frame.
            shadow_q <= {shadow_q[PLATE_W-9:0], bus.data_byte};
            csum_q   <= csum_q ^ bus.data_byte;
            if (idx_q == 3'(PLATE_BYTES - 1)) begin
              state_q <= StCheck;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
          StCheck: begin
            if (bus.data_byte == csum_q) begin
              state_q <= StTail;
            end else begin
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              err_pulse_q <= 1'b1;
              err_code_q  <= ERR_CSUM;
            end
          end
          StTail: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if (bus.data_byte == TAIL_BYTE) begin
              plate_data_q  <= shadow_q;
              plate_valid_q <= 1'b1;
              good_cnt_q    <= good_cnt_q + 8'd1;
              // Overwriting unconsumed data, unless the consumer acks in this same cycle.
              if (plate_valid_q && !bus.plate_ack) begin
                overrun_q <= 1'b1;
              end
            end else begin
              err_pulse_q <= 1'b1;
              err_code_q  <= ERR_TAIL;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.plate_data  = plate_data_q;
  assign bus.plate_valid = plate_valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.err_pulse   = err_pulse_q;
  assign bus.err_code    = err_code_q;
  assign bus.busy        = busy_q;
  assign bus.good_cnt    = good_cnt_q;

endmodule

// File: tb/tb_plate_frame_ctrl.sv
// Directed bench for plate_frame_ctrl: good frames, checksum/tail/timeout errors, handshake, reset.
module tb_plate_frame_ctrl;

  localparam int unsigned TimeoutCyc = 20;

  localparam logic [55:0] P1  = 56'h4A414231323334;  // "JAB1234"
  localparam logic [7:0]  C1  = 8'h4D;               // XOR of P1 payload bytes
  localparam logic [55:0] P2  = 56'h01020304050607;
  localparam logic [7:0]  C2  = 8'h00;               // XOR of 01..07

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  plate_frame_ctrl_if bus ();

  plate_frame_ctrl #(
    .HEAD_BYTE   (8'hAA),
    .TAIL_BYTE   (8'h55),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the next posedge, returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_done   = 1'b1;
    bus.data_byte = b;
    @(negedge clk);
    bus.rx_done   = 1'b0;
    bus.data_byte = 8'h00;
  endtask

  task automatic send_head_and(input logic [55:0] p, input int n);
    send_byte(8'hAA);
    for (int i = 0; i < n; i++) send_byte(p[55-8*i -: 8]);
  endtask

  task automatic send_frame(input logic [55:0] p, input logic [7:0] cs, input logic [7:0] tl,
                            input bit ack_on_tail);
    send_head_and(p, 7);
    send_byte(cs);
    bus.plate_ack = ack_on_tail;
    send_byte(tl);
    bus.plate_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.plate_ack = 1'b1;
    @(negedge clk);
    bus.plate_ack = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.rx_done   = 1'b0;
    bus.data_byte = 8'h00;
    bus.plate_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_data", 64'(bus.plate_data), 64'd0);
    check("rst_valid", 64'(bus.plate_valid), 64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    check("rst_errp", 64'(bus.err_pulse), 64'd0);
    check("rst_code", 64'(bus.err_code), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_cnt", 64'(bus.good_cnt), 64'd0);

    // 1: good frame
    send_frame(P1, C1, 8'h55, 1'b0);
    check("t1_data", 64'(bus.plate_data), 64'(P1));
    check("t1_valid", 64'(bus.plate_valid), 64'd1);
    check("t1_cnt", 64'(bus.good_cnt), 64'd1);
    check("t1_errp", 64'(bus.err_pulse), 64'd0);
    check("t1_code", 64'(bus.err_code), 64'd0);
    check("t1_busy", 64'(bus.busy), 64'd0);
    pulse_ack();
    check("t1_ack_valid", 64'(bus.plate_valid), 64'd0);

    // 2: bad checksum, then a good frame is still accepted
    send_head_and(P1, 7);
    send_byte(8'h7D);
    check("t2_errp", 64'(bus.err_pulse), 64'd1);
    check("t2_code", 64'(bus.err_code), 64'd2);
    check("t2_busy", 64'(bus.busy), 64'd0);
    check("t2_data", 64'(bus.plate_data), 64'(P1));
    check("t2_cnt", 64'(bus.good_cnt), 64'd1);
    send_byte(8'h55);  // stray tail in idle: ignored
    check("t2_errp_once", 64'(bus.err_pulse), 64'd0);
    send_frame(P2, C2, 8'h55, 1'b0);
    check("t2_good_data", 64'(bus.plate_data), 64'(P2));
    check("t2_good_cnt", 64'(bus.good_cnt), 64'd2);
    check("t2_code_hold", 64'(bus.err_code), 64'd2);

    // 3: leading garbage ignored, then bad tail
    pulse_ack();
    send_byte(8'h00);
    send_byte(8'hFF);
    check("t3_garb_errp", 64'(bus.err_pulse), 64'd0);
    check("t3_garb_busy", 64'(bus.busy), 64'd0);
    send_byte(8'hAA);
    check("t3_busy_rise", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 7; i++) send_byte(P1[55-8*i -: 8]);
    send_byte(C1);
    check("t3_busy_tail", 64'(bus.busy), 64'd1);
    send_byte(8'h56);
    check("t3_errp", 64'(bus.err_pulse), 64'd1);
    check("t3_code", 64'(bus.err_code), 64'd3);
    check("t3_busy", 64'(bus.busy), 64'd0);
    check("t3_cnt", 64'(bus.good_cnt), 64'd2);
    check("t3_data", 64'(bus.plate_data), 64'(P2));
    check("t3_valid", 64'(bus.plate_valid), 64'd0);

    // 4: timeout after 3 payload bytes; fires TimeoutCyc cycles after the last byte
    send_head_and(P1, 3);
    for (int i = 0; i < int'(TimeoutCyc) - 1; i++) begin
      check("t4_wait_errp", 64'(bus.err_pulse), 64'd0);
      @(negedge clk);
    end
    check("t4_pre_errp", 64'(bus.err_pulse), 64'd0);
    check("t4_pre_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("t4_errp", 64'(bus.err_pulse), 64'd1);
    check("t4_code", 64'(bus.err_code), 64'd1);
    check("t4_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("t4_errp_once", 64'(bus.err_pulse), 64'd0);

    // 4b: byte exactly on the terminal cycle is accepted, no timeout
    send_head_and(P1, 3);
    repeat (TimeoutCyc - 1) @(negedge clk);
    send_byte(P1[31:24]);
    check("t4b_errp", 64'(bus.err_pulse), 64'd0);
    check("t4b_busy", 64'(bus.busy), 64'd1);
    for (int i = 4; i < 7; i++) send_byte(P1[55-8*i -: 8]);
    send_byte(C1);
    send_byte(8'h55);
    check("t4b_cnt", 64'(bus.good_cnt), 64'd3);
    check("t4b_data", 64'(bus.plate_data), 64'(P1));
    check("t4b_code", 64'(bus.err_code), 64'd1);

    // 5: overrun without ack, then ack clears both
    send_frame(P2, C2, 8'h55, 1'b0);
    check("t5_overrun", 64'(bus.overrun), 64'd1);
    check("t5_data", 64'(bus.plate_data), 64'(P2));
    check("t5_valid", 64'(bus.plate_valid), 64'd1);
    check("t5_cnt", 64'(bus.good_cnt), 64'd4);
    pulse_ack();
    check("t5_ack_valid", 64'(bus.plate_valid), 64'd0);
    check("t5_ack_overrun", 64'(bus.overrun), 64'd0);
    pulse_ack();  // ack with nothing pending: no effect
    check("t5_idle_ack", 64'(bus.plate_valid), 64'd0);

    // 5b: ack coincident with completion
    send_frame(P1, C1, 8'h55, 1'b0);
    check("t5b_pre_valid", 64'(bus.plate_valid), 64'd1);
    send_frame(P2, C2, 8'h55, 1'b1);
    check("t5b_valid", 64'(bus.plate_valid), 64'd1);
    check("t5b_overrun", 64'(bus.overrun), 64'd0);
    check("t5b_data", 64'(bus.plate_data), 64'(P2));
    check("t5b_cnt", 64'(bus.good_cnt), 64'd6);

    // 6: reset mid-frame after 4 payload bytes
    send_head_and(P1, 4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_data", 64'(bus.plate_data), 64'd0);
    check("t6_valid", 64'(bus.plate_valid), 64'd0);
    check("t6_overrun", 64'(bus.overrun), 64'd0);
    check("t6_code", 64'(bus.err_code), 64'd0);
    check("t6_busy", 64'(bus.busy), 64'd0);
    check("t6_cnt", 64'(bus.good_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(P1, C1, 8'h55, 1'b0);
    check("t6_post_cnt", 64'(bus.good_cnt), 64'd1);
    check("t6_post_data", 64'(bus.plate_data), 64'(P1));

    // 6b: 256 good frames in total wrap the counter to zero
    for (int n = 0; n < 254; n++) send_frame(P2, C2, 8'h55, 1'b1);
    check("t6_cnt_255", 64'(bus.good_cnt), 64'd255);
    send_frame(P2, C2, 8'h55, 1'b0);
    check("t6_cnt_wrap", 64'(bus.good_cnt), 64'd0);
    check("t6_wrap_errp", 64'(bus.err_pulse), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
